hex_display_ctrl: RTL and testbench
===================================

Name: hex_display_ctrl

Overview:
- Parametrised multi-digit hex display controller for the DE1-SoC HEX bank. It succeeds the single-digit combinational decoder.
- A value is captured through a ready/load handshake. A single shared decoder then serially decodes it one digit per cycle, MSB first, with optional leading-zero blanking and a per-digit blank mask.
- Decoded segments are committed to all displays atomically. An optional blink mode runs off a free-running prescaler.
- Sits between datapath/FSM logic and the HEXn output pins.

Parameters:
- NUM_DIGITS, 6, number of 7-segment digits driven (legal 1..8).
- BLINK_DIV, 25000000, clock cycles per blink half-period (legal >= 2); 0.5 s at 50 MHz.

Ports:
- clock  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (nibble 0 = rightmost).
- load  in  1  request to capture value/blank_lz/digit_mask; honoured only while ready=1.
- blank_lz  in  1  leading-zero blanking enable, captured on load.
- digit_mask  in  NUM_DIGITS  1 = force digit i blank, captured on load.
- blink_en  in  1  live (not captured) blink enable.
- ready  out  1  controller idle, can accept load.
- done  out  1  one-cycle pulse when new segments are committed.
- hex  out  7*NUM_DIGITS  active-low segments; hex[7i+6:7i] = digit i, bit 0 = seg a ... bit 6 = seg g.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clock, resetn).
- Reset values: state IDLE, ready=1, done=0, committed and shadow segments all 7'h7F (all digits dark), blink counter 0, blink phase 0.
- Decode table (active-low, g..a), nibbles 0-F:
  - 0-7: 40, 79, 24, 30, 19, 12, 02, 78
  - 8-F: 00, 10, 08, 03, 46, 21, 06, 0E
  - blank = 7F
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - ready=1.
  - On an edge with load=1: capture value, blank_lz, digit_mask; set idx=NUM_DIGITS-1, nz_seen=0; go to SCAN.
  - ready drops the cycle after accept.
- SCAN: each edge processes digit idx into shadow[idx]:
  - If digit_mask[idx]=1, shadow[idx]=7F.
  - Else if blank_lz=1, nz_seen=0, nibble=0 and idx!=0, shadow[idx]=7F.
  - Else shadow[idx]=decode(nibble).
  - nz_seen is set when the nibble is nonzero, regardless of mask (a masked nonzero digit ends leading-zero run).
  - Digit 0 is never lz-blanked, so value 0 shows a single "0".
  - If idx=0 go to COMMIT, else idx decrements.
- COMMIT: next edge copies shadow to committed, asserts done for exactly that following cycle, returns to IDLE (ready=1).
- Latency: accept edge E0; commit at edge E(NUM_DIGITS+1). ready is low for NUM_DIGITS+1 cycles. done is high in the cycle after E(NUM_DIGITS+1).
- hex holds the previous committed image throughout a scan; no partial updates are visible.
- load while ready=0 is ignored (no queueing). load held high in IDLE is accepted again the cycle ready returns; back-to-back updates are legal.
- Blink:
  - Counter counts 0..BLINK_DIV-1 continuously, independent of blink_en and FSM.
  - On the edge where count=BLINK_DIV-1: count goes to 0 and phase toggles.
  - hex = (blink_en & phase) ? all 7F : committed (combinational mux from registers; blink_en takes effect without delay).
- Reset mid-scan aborts immediately: no commit, no done, displays dark.

Test Plan (NUM_DIGITS=4, BLINK_DIV=4):
1. Reset: assert resetn=0 mid-run -> hex=28'hFFFFFFF, ready=1, done=0 immediately, asynchronously.
2. Basic load: value=16'h1A3F, blank_lz=0, mask=0, load 1 cycle -> ready low 5 cycles, hex unchanged until commit. After the 5th edge: hex[27:21]=79, [20:14]=08, [13:7]=30, [6:0]=0E, and done high one cycle.
3. Leading-zero blanking, blank_lz=1:
   - 16'h0040 -> digits 3,2 = 7F, digit 1 = 19, digit 0 = 40.
   - 16'h0000 -> 7F,7F,7F,40.
   - 16'h0400 -> 7F,19,40,40.
4. Mask: value=16'h0234, mask=4'b0100, blank_lz=1 -> 7F,7F,30,19. Then mask=4'b1000 with 16'h1000 -> digit 3 blank, digits 2..0 = 40,40,40 (masked nonzero ends lz run).
5. Busy and abort:
   - Pulse load with 16'hFFFF during a scan of 16'h1234 -> result 1234 (79,24,30,19), one done only.
   - New load then resetn low on 2nd scan cycle -> all 7F, no done.
6. Blink: with 16'h1234 committed, blink_en=1 -> hex alternates committed / 28'hFFFFFFF every 4 cycles. Deassert blink_en while dark -> committed image in the same cycle.

Source files
------------

// File: rtl/hex_display_ctrl_if.sv
// Load handshake between a producer and hex_display_ctrl: value, blanking controls, ready/done.
interface hex_display_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   digit_mask;
    logic                    ready;
    logic                    done;

    modport master (output value, load, blank_lz, digit_mask, input ready, done);
    modport slave  (input value, load, blank_lz, digit_mask, output ready, done);
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit 7-segment controller: serial MSB-first decode into a shadow image,
// atomic commit to the displays, optional blink driven by a free-running prescaler.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clock,
    input  logic                    resetn,
    hex_display_ctrl_if.slave       bus,
    input  logic                    blink_en,
    output logic [7*NUM_DIGITS-1:0] hex
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic                    nz_seen;
    logic [4*NUM_DIGITS-1:0] val_q;
    logic                    blz_q;
    logic [NUM_DIGITS-1:0]   mask_q;
    logic [7*NUM_DIGITS-1:0] shadow;
    logic [7*NUM_DIGITS-1:0] committed;
    logic [CNT_W-1:0]        cnt;
    logic                    phase;
    logic [3:0]              nib;
    logic                    msk;
    logic [6:0]              seg;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;  default: decode = 7'h0E;
        endcase
    endfunction

    // Single shared decoder: select the nibble and mask bit of the digit under scan
    always_comb begin
        nib = '0;
        msk = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib = val_q[4*i +: 4];
                msk = mask_q[i];
            end
        end
        if (msk)
            seg = 7'h7F;
        else if (blz_q && !nz_seen && nib == 4'h0 && idx != '0)
            seg = 7'h7F;
        else
            seg = decode(nib);
    end

    // Captured request is only meaningful once SCAN starts, so it carries no reset
    always_ff @(posedge clock) begin
        if (state == IDLE && bus.load) begin
            val_q  <= bus.value;
            blz_q  <= bus.blank_lz;
            mask_q <= bus.digit_mask;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
            idx       <= '0;
            nz_seen   <= 1'b0;
            shadow    <= '1;
            committed <= '1;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.load) begin
                        bus.ready <= 1'b0;
                        idx       <= IDX_W'(NUM_DIGITS - 1);
                        nz_seen   <= 1'b0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        if (idx == IDX_W'(i))
                            shadow[7*i +: 7] <= seg;
                    nz_seen <= nz_seen | (nib != 4'h0);
                    if (idx == '0)
                        state <= COMMIT;
                    else
                        idx <= idx - 1'b1;
                end
                COMMIT: begin
                    committed <= shadow;
                    bus.done  <= 1'b1;
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_W'(BLINK_DIV - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hex = (blink_en && phase) ? '1 : committed;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomised and directed bench for hex_display_ctrl (4 digits, blink every 4 cycles).
module tb_hex_display_ctrl;
    localparam int N   = 4;
    localparam int DIV = 4;
    localparam logic [27:0] DARK = 28'hFFFFFFF;

    logic clock = 1'b0;
    logic resetn;
    logic blink_en;
    logic [7*N-1:0] hex;

    hex_display_ctrl_if #(.NUM_DIGITS(N)) bus ();

    hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(DIV)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bus      (bus),
        .blink_en (blink_en),
        .hex      (hex)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-image decode from the display rules, plus cycle counting
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [27:0] image_of(input logic [15:0] v, input logic blz,
                                             input logic [3:0] m);
        logic [27:0] img;
        logic seen;
        logic [3:0] d;
        seen = 1'b0;
        img = '1;
        for (int k = N - 1; k >= 0; k--) begin
            d = v[4*k +: 4];
            if (m[k]) img[7*k +: 7] = 7'h7F;
            else if (blz && !seen && d == 4'h0 && k != 0) img[7*k +: 7] = 7'h7F;
            else img[7*k +: 7] = seg_tab[d];
            if (d != 4'h0) seen = 1'b1;
        end
        return img;
    endfunction

    logic [27:0] m_img = DARK;
    logic [27:0] m_pend = DARK;
    logic        m_ready = 1'b1;
    logic        m_done = 1'b0;
    int          m_left = 0;
    int          m_cnt = 0;
    logic        m_phase = 1'b0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_img = DARK; m_ready = 1'b1; m_done = 1'b0; m_left = 0;
            m_cnt = 0; m_phase = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_img = m_pend; m_done = 1'b1; m_ready = 1'b1;
                end
            end else if (bus.load) begin
                m_pend  = image_of(bus.value, bus.blank_lz, bus.digit_mask);
                m_left  = N + 1;
                m_ready = 1'b0;
            end
            if (m_cnt == DIV - 1) begin
                m_cnt = 0; m_phase = ~m_phase;
            end else m_cnt++;
        end
    end

    always @(negedge clock) begin
        chk("hex", 64'(hex), 64'((blink_en && m_phase) ? DARK : m_img));
        chk("ready", 64'(bus.ready), 64'(m_ready));
        chk("done", 64'(bus.done), 64'(m_done));
        if (bus.done) n_done++;
    end

    task automatic do_load(input logic [15:0] v, input logic blz, input logic [3:0] m);
        @(posedge clock); #1;
        bus.value = v; bus.blank_lz = blz; bus.digit_mask = m; bus.load = 1'b1;
        @(posedge clock); #1;
        bus.load = 1'b0;
    endtask

    task automatic load_and_commit(input logic [15:0] v, input logic blz, input logic [3:0] m,
                                   input logic [27:0] exp, input string name);
        do_load(v, blz, m);
        repeat (N) @(posedge clock);
        #1 chk({name, "_held"}, 64'(hex), 64'(m_img));
        chk({name, "_busy"}, 64'(bus.ready), 64'(0));
        @(posedge clock); #1;
        chk(name, 64'(hex), 64'(exp));
        chk({name, "_done"}, 64'(bus.done), 64'(1));
        @(posedge clock); #1;
        chk({name, "_done_clr"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        logic [31:0] r;
        int dark_cycles;
        resetn = 1'b0; blink_en = 1'b0;
        bus.value = '0; bus.load = 1'b0; bus.blank_lz = 1'b0; bus.digit_mask = '0;
        repeat (3) @(posedge clock);
        #1 chk("rst_hex", 64'(hex), 64'(DARK));
        chk("rst_ready", 64'(bus.ready), 64'(1));
        chk("rst_done", 64'(bus.done), 64'(0));
        resetn = 1'b1;

        load_and_commit(16'h1A3F, 1'b0, 4'b0000, {7'h79, 7'h08, 7'h30, 7'h0E}, "basic");
        load_and_commit(16'h0040, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h19, 7'h40}, "lz_0040");
        load_and_commit(16'h0000, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "lz_0000");
        load_and_commit(16'h0400, 1'b1, 4'b0000, {7'h7F, 7'h19, 7'h40, 7'h40}, "lz_0400");
        load_and_commit(16'h0234, 1'b1, 4'b0100, {7'h7F, 7'h7F, 7'h30, 7'h19}, "mask_0234");
        load_and_commit(16'h1000, 1'b1, 4'b1000, {7'h7F, 7'h40, 7'h40, 7'h40}, "mask_1000");

        // Load during a scan is ignored
        n_done = 0;
        do_load(16'h1234, 1'b0, 4'b0000);
        @(posedge clock); #1;
        bus.value = 16'hFFFF; bus.load = 1'b1;
        @(posedge clock); #1;
        bus.load = 1'b0;
        repeat (3) @(posedge clock);
        #1 chk("busy_ign", 64'(hex), 64'({7'h79, 7'h24, 7'h30, 7'h19}));
        repeat (6) @(posedge clock);
        #1 chk("busy_one_done", 64'(n_done), 64'(1));

        // Asynchronous reset mid-scan
        n_done = 0;
        do_load(16'h5678, 1'b0, 4'b0000);
        @(posedge clock); #3;
        resetn = 1'b0;
        #1 chk("abort_hex", 64'(hex), 64'(DARK));
        chk("abort_ready", 64'(bus.ready), 64'(1));
        chk("abort_done", 64'(bus.done), 64'(0));
        repeat (2) @(posedge clock);
        #3 resetn = 1'b1;
        repeat (8) @(posedge clock);
        #1 chk("abort_no_done", 64'(n_done), 64'(0));
        chk("abort_dark", 64'(hex), 64'(DARK));

        // Blink
        load_and_commit(16'h1234, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, "blink_img");
        blink_en = 1'b1;
        dark_cycles = 0;
        repeat (16) begin
            @(negedge clock);
            if (hex == DARK) dark_cycles++;
        end
        chk("blink_duty", 64'(dark_cycles), 64'(8));
        for (int i = 0; i < 10 && hex != DARK; i++) @(posedge clock) #1;
        chk("blink_dark", 64'(hex), 64'(DARK));
        blink_en = 1'b0;
        #1 chk("blink_off", 64'(hex), 64'({7'h79, 7'h24, 7'h30, 7'h19}));

        // Random traffic, including loads while busy and back-to-back requests
        for (int it = 0; it < 400; it++) begin
            @(posedge clock); #1;
            r = $urandom;
            bus.value = r[15:0] >> ($urandom_range(0, 3) * 4);
            bus.blank_lz = r[16];
            bus.digit_mask = (r[19:17] == 3'd0) ? r[23:20] : 4'b0000;
            bus.load = ($urandom_range(0, 2) == 0);
            blink_en = ($urandom_range(0, 4) == 0);
        end
        bus.load = 1'b0; blink_en = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
